// File: rtl/alu_trace_pkg.sv
// Shared state encoding and default sizing for the ALU trace buffer.
package alu_trace_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_e;

endpackage : alu_trace_pkg

// File: rtl/trace_fifo.sv
// Circular storage for captured ALU words. The caller decides acceptance;
// push_i/pop_i are only asserted for transfers that must happen.
module trace_fifo
  import alu_trace_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        push_data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        pop_data_o,
  output logic                     pop_valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] pop_data_q;
  logic              pop_valid_q;

  // NOTE: the storage array has no reset; emptiness is defined by count and
  // pointers alone, so clearing them is enough and keeps the array as plain RAM.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) begin
      mem[wr_ptr_q] <= push_data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
    end else if (clear_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      pop_valid_q <= pop_i;
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
        pop_data_q <= mem[rd_ptr_q];
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign pop_data_o  = pop_data_q;
  assign pop_valid_o = pop_valid_q;
  assign count_o     = count_q;
  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);

endmodule : trace_fifo

// File: rtl/alu_trace_buffer.sv
// Triggered capture of retired ALU results into a readable trace FIFO.
// Optional running signature enabled by defining ALU_TRACE_SIGNATURE_EN.
module alu_trace_buffer
  import alu_trace_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int STOP_ON_FULL = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      alu_out,
  input  logic                   alu_valid,
  input  logic                   arm,
  input  logic                   stop,
  input  logic                   clear,
  input  logic [DATA_W-1:0]      trig_value,
  input  logic [DATA_W-1:0]      trig_mask,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic [1:0]             state,
  output logic [DATA_W-1:0]      signature
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  trace_state_e state_q, state_d;
  logic         overflow_q;
  logic         trig_hit, push_req, push_acc, pop_acc, going_full;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d    = state_q;
    pop_acc    = rd_en && !empty && !clear;
    trig_hit   = alu_valid && (((alu_out ^ trig_value) & trig_mask) == '0);
    push_req   = !clear && ((state_q == ST_ARMED && !stop && trig_hit) ||
                            (state_q == ST_CAPTURE && alu_valid));
    push_acc   = push_req && (!full || pop_acc);
    going_full = push_acc && !pop_acc && (count == CNT_W'(DEPTH - 1));

    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm && !stop) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (stop)          state_d = ST_DONE;
          else if (trig_hit) state_d = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          // Stop on the write that fills the buffer, so the next word is not dropped.
          if (stop || ((STOP_ON_FULL != 0) && (going_full || (full && !pop_acc))))
            state_d = ST_DONE;
        end
        ST_DONE: begin
          if (arm && !stop) state_d = ST_ARMED;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clear)                      overflow_q <= 1'b0;
      else if (push_req && !push_acc) overflow_q <= 1'b1;
    end
  end

`ifdef ALU_TRACE_SIGNATURE_EN
  logic [DATA_W-1:0] signature_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      signature_q <= '0;
    end else if (clear) begin
      signature_q <= '0;
    end else if (push_acc) begin
      signature_q <= {signature_q[DATA_W-2:0], signature_q[DATA_W-1]} ^ alu_out;
    end
  end

  assign signature = signature_q;
`else
  assign signature = '0;
`endif

  trace_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .clear_i     (clear),
    .push_i      (push_acc),
    .push_data_i (alu_out),
    .pop_i       (pop_acc),
    .pop_data_o  (rd_data),
    .pop_valid_o (rd_valid),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty)
  );

  assign overflow = overflow_q;
  assign state    = state_q;

endmodule : alu_trace_buffer

// File: tb/tb_alu_trace_buffer.sv
// Directed bench: one stop-on-full and one free-running instance share stimulus.
module tb_alu_trace_buffer;

  localparam int DW = 32;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] alu_out, trig_value, trig_mask;
  logic          alu_valid, arm, stop, clear, rd_en;

  logic [DW-1:0] a_rd_data, b_rd_data, a_sig, b_sig;
  logic          a_rd_valid, b_rd_valid, a_full, b_full, a_empty, b_empty, a_ovf, b_ovf;
  logic [4:0]    a_count, b_count;
  logic [1:0]    a_state, b_state;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_trace_buffer #(.DATA_W(DW), .DEPTH(DP), .STOP_ON_FULL(1)) u_a (
    .clk(clk), .reset(reset), .alu_out(alu_out), .alu_valid(alu_valid),
    .arm(arm), .stop(stop), .clear(clear), .trig_value(trig_value),
    .trig_mask(trig_mask), .rd_en(rd_en), .rd_data(a_rd_data),
    .rd_valid(a_rd_valid), .count(a_count), .full(a_full), .empty(a_empty),
    .overflow(a_ovf), .state(a_state), .signature(a_sig)
  );

  alu_trace_buffer #(.DATA_W(DW), .DEPTH(DP), .STOP_ON_FULL(0)) u_b (
    .clk(clk), .reset(reset), .alu_out(alu_out), .alu_valid(alu_valid),
    .arm(arm), .stop(stop), .clear(clear), .trig_value(trig_value),
    .trig_mask(trig_mask), .rd_en(rd_en), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .count(b_count), .full(b_full), .empty(b_empty),
    .overflow(b_ovf), .state(b_state), .signature(b_sig)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; step(); arm = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    alu_valid = 1'b1; alu_out = w; step(); alu_valid = 1'b0;
  endtask

  task automatic pop_a(input string tag, input logic [DW-1:0] exp);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    check({tag, "_valid"}, a_rd_valid, 1);
    check({tag, "_data"}, a_rd_data, exp);
  endtask

  function automatic logic [DW-1:0] exp_sig(input logic [DW-1:0] with_macro);
`ifdef ALU_TRACE_SIGNATURE_EN
    return with_macro;
`else
    return '0;
`endif
  endfunction

  initial begin
    reset = 1'b0; alu_out = '0; alu_valid = 1'b0; arm = 1'b0; stop = 1'b0;
    clear = 1'b0; rd_en = 1'b0; trig_value = '0; trig_mask = '0;
    step(); step();
    check("rst_state", a_state, 0);
    check("rst_count", a_count, 0);
    check("rst_empty", a_empty, 1);
    check("rst_full", a_full, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_rd_valid", a_rd_valid, 0);
    check("rst_rd_data", a_rd_data, 0);
    check("rst_sig", a_sig, 0);
    reset = 1'b1;
    step();

    // Any-valid trigger, three words, stop, drain in order.
    pulse_arm();
    check("t1_armed", a_state, 1);
    push_word(32'h1);
    check("t1_capture", a_state, 2);
    check("t1_count1", a_count, 1);
    check("t1_sig1", a_sig, exp_sig(32'h1));
    push_word(32'h2);
    check("t1_sig2", a_sig, exp_sig(32'h0));
    push_word(32'h3);
    check("t1_count3", a_count, 3);
    check("t1_sig3", a_sig, exp_sig(32'h3));
    pulse_stop();
    check("t1_done", a_state, 3);
    pop_a("t1_pop1", 32'h1);
    check("t1_count2", a_count, 2);
    pop_a("t1_pop2", 32'h2);
    pop_a("t1_pop3", 32'h3);
    check("t1_count0", a_count, 0);
    check("t1_empty", a_empty, 1);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    check("t1_pop_empty_valid", a_rd_valid, 0);
    check("t1_pop_empty_count", a_count, 0);

    // Masked trigger: only the low byte is compared.
    pulse_clear();
    check("t2_clear_state", a_state, 0);
    check("t2_clear_sig", a_sig, 0);
    trig_value = 32'h40; trig_mask = 32'hFF;
    pulse_arm();
    push_word(32'h10);
    check("t2_no_trig_state", a_state, 1);
    check("t2_no_trig_count", a_count, 0);
    push_word(32'h140);
    check("t2_trig_state", a_state, 2);
    check("t2_trig_count", a_count, 1);
    push_word(32'h7);
    pulse_stop();
    pop_a("t2_pop1", 32'h140);
    pop_a("t2_pop2", 32'h7);
    check("t2_empty", a_empty, 1);

    // Twenty words into a sixteen-entry buffer, both stop policies.
    pulse_clear();
    trig_value = '0; trig_mask = '0;
    pulse_arm();
    for (int i = 0; i < 20; i++) push_word(DW'(i + 1));
    check("t3a_count", a_count, 16);
    check("t3a_full", a_full, 1);
    check("t3a_state", a_state, 3);
    check("t3a_ovf", a_ovf, 0);
    check("t3b_count", b_count, 16);
    check("t3b_state", b_state, 2);
    check("t3b_ovf", b_ovf, 1);
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1; step(); rd_en = 1'b0;
      check($sformatf("t3a_pop%0d", i), a_rd_data, 64'(i + 1));
      check($sformatf("t3b_pop%0d", i), b_rd_data, 64'(i + 1));
    end
    check("t3b_empty", b_empty, 1);

    // Simultaneous push and pop while full (free-running instance).
    pulse_clear();
    check("t4_clear_ovf", b_ovf, 0);
    pulse_arm();
    for (int i = 0; i < 16; i++) push_word(DW'(32'hA0 + i));
    check("t4b_full", b_full, 1);
    check("t4b_state", b_state, 2);
    alu_valid = 1'b1; alu_out = 32'hEE; rd_en = 1'b1;
    step();
    alu_valid = 1'b0; rd_en = 1'b0;
    check("t4b_count", b_count, 16);
    check("t4b_rd_valid", b_rd_valid, 1);
    check("t4b_rd_data", b_rd_data, 32'hA0);
    check("t4b_ovf", b_ovf, 0);
    check("t4a_count", a_count, 15);
    for (int i = 1; i < 17; i++) begin
      rd_en = 1'b1; step(); rd_en = 1'b0;
      check($sformatf("t4b_order%0d", i), b_rd_data, (i == 16) ? 64'hEE : 64'(32'hA0 + i));
    end
    check("t4b_empty", b_empty, 1);

    // Command precedence.
    pulse_clear();
    arm = 1'b1; stop = 1'b1; step(); arm = 1'b0; stop = 1'b0;
    check("t5_idle_arm_stop", a_state, 0);
    pulse_arm();
    arm = 1'b1; stop = 1'b1; step(); arm = 1'b0; stop = 1'b0;
    check("t5_armed_arm_stop", a_state, 3);
    pulse_arm();
    clear = 1'b1; arm = 1'b1; alu_valid = 1'b1; alu_out = 32'h55;
    step();
    clear = 1'b0; arm = 1'b0; alu_valid = 1'b0;
    check("t5_clear_wins_state", a_state, 0);
    check("t5_clear_wins_count", a_count, 0);

    // Asynchronous reset in the middle of a capture.
    pulse_arm();
    push_word(32'h5);
    push_word(32'h6);
    pop_a("t6_pop", 32'h5);
    reset = 1'b0;
    #1;
    check("t6_state", a_state, 0);
    check("t6_count", a_count, 0);
    check("t6_empty", a_empty, 1);
    check("t6_rd_valid", a_rd_valid, 0);
    check("t6_rd_data", a_rd_data, 0);
    check("t6_sig", a_sig, 0);
    check("t6_ovf", a_ovf, 0);
    step();
    reset = 1'b1;
    step();
    check("t6_after_count", a_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_alu_trace_buffer
